multi: RTL and testbench
========================

MULTI -- requirements
Module: multi

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 32 bits and product width at 64 bits.
REQ-002 SHALL have port `clock`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port `mlier`, input, 32 bits: unsigned multiplier operand.
REQ-005 SHALL have port `mcand`, input, 32 bits: unsigned multiplicand operand.
REQ-006 SHALL have port `prodt`, output, 64 bits: registered product.
REQ-007 SHALL have port `start`, input, 1 bit: level-sensitive request; held high for the whole operation.
REQ-008 SHALL have port `valid`, output, 1 bit: registered, high while `prodt` holds a completed product.
REQ-009 SHALL use the port order (clock, reset, mlier, mcand, prodt, start, valid).

Function
REQ-010 SHALL compute the unsigned product mlier*mcand with the full 64-bit result and no truncation, using a sequential shift-add datapath (one multiplier bit per cycle).
REQ-011 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-012 In IDLE with start=1 at a rising edge: SHALL capture mlier and mcand into internal registers, clear the accumulator and the 6-bit iteration counter, drive valid=0, and go to BUSY.
REQ-013 In IDLE with start=0: SHALL remain in IDLE with valid=0 and hold prodt.
REQ-014 In BUSY, each rising edge SHALL process one multiplier bit, LSB first: if the bit is 1, add the shifted multiplicand to the accumulator; then advance the shift and increment the counter.
REQ-015 After exactly 32 BUSY iterations, SHALL load the final product into prodt, set valid=1, and go to DONE; valid rises on the 32nd rising edge after the load edge.
REQ-016 In DONE, SHALL hold prodt and valid=1 while start=1; on start=0, SHALL go to IDLE and clear valid on that edge, keeping prodt unchanged.
REQ-017 start=0 in BUSY SHALL abort: return to IDLE, valid=0, with no product update.
REQ-018 Operand changes after the load edge SHALL NOT affect the result in progress.
REQ-019 A new operation SHALL start only from IDLE; after DONE, start must go low for at least one cycle before the next operation.
REQ-020 The zero operand case SHALL take the full 32 iterations and yield prodt=0 with valid=1.
REQ-021 prodt SHALL change only at completion (REQ-015) or on reset; it SHALL NOT expose intermediate accumulator values.

Reset
REQ-022 reset=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, prodt=0, valid=0, counter=0 and internal operand/accumulator registers to 0.
REQ-023 Asserting reset during BUSY or DONE SHALL discard the operation; after release the block SHALL wait in IDLE for start.
REQ-024 Release of reset SHALL take effect on the next rising edge; start sampled high on that edge begins an operation.

Verification
REQ-025 mlier=0x8, mcand=0x00012345, start held 33 cycles -> valid=1 at cycle 32, prodt=0x0000000000091A28.
REQ-026 Back-to-back runs with 1-cycle start=0 gaps, mcand=0x000FFFFF and mlier=0x2/0x4/0x8 -> prodt=0x1FFFFE / 0x3FFFFC / 0x7FFFF8; valid drops during each gap.
REQ-027 mlier=0x1 then mlier=0x0 with mcand=0x00012345 -> prodt=0x12345, then prodt=0 with valid=1.
REQ-028 mlier=mcand=0xFFFFFFFF -> prodt=0xFFFFFFFE00000001.
REQ-029 Operands changed mid-BUSY -> result uses the operands captured at load; start dropped at cycle 10 -> valid stays 0, prodt unchanged.
REQ-030 reset pulsed low mid-BUSY, asynchronously and between clock edges -> prodt=0 and valid=0 immediately; the next full run gives the correct product.

Source files
------------

// File: rtl/multi.sv
// Sequential 32x32 unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports: clock, reset (async active-low), mlier/mcand in, prodt/valid out, start level request.
module multi (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mlier,
  input  logic [31:0] mcand,
  output logic [63:0] prodt,
  input  logic        start,
  output logic        valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] mlr, mlr_n;
  logic [63:0] mcd, mcd_n;
  logic [63:0] acc, acc_n;
  logic [5:0]  cnt, cnt_n;
  logic [63:0] prodt_n;
  logic        valid_n;
  logic [63:0] acc_add;
  logic        last;

  // Accumulator value after folding in the current multiplier bit.
  assign acc_add = acc + (mlr[0] ? mcd : 64'd0);
  assign last    = (cnt == 6'd31);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) state_n = BUSY;
      end
      BUSY: begin
        if (!start)    state_n = IDLE;
        else if (last) state_n = DONE;
      end
      DONE: begin
        if (!start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    mlr_n   = mlr;
    mcd_n   = mcd;
    acc_n   = acc;
    cnt_n   = cnt;
    prodt_n = prodt;
    valid_n = valid;
    unique case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (start) begin
          mlr_n = mlier;
          mcd_n = {32'd0, mcand};
          acc_n = 64'd0;
          cnt_n = 6'd0;
        end
      end
      BUSY: begin
        valid_n = 1'b0;
        if (start) begin
          acc_n = acc_add;
          mlr_n = mlr >> 1;
          mcd_n = mcd << 1;
          cnt_n = cnt + 6'd1;
          // Only the finished sum reaches prodt.
          if (last) begin
            prodt_n = acc_add;
            valid_n = 1'b1;
          end
        end
      end
      DONE: begin
        valid_n = start;
      end
      default: valid_n = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mlr   <= 32'd0;
      mcd   <= 64'd0;
      acc   <= 64'd0;
      cnt   <= 6'd0;
      prodt <= 64'd0;
      valid <= 1'b0;
    end else begin
      mlr   <= mlr_n;
      mcd   <= mcd_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      prodt <= prodt_n;
      valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_multi.sv
// Scoreboard bench for multi: directed operands, products checked on valid rise.
// A monitor pops expected products; tasks check latency, hold, abort and reset.
module tb_multi;

  logic        clock;
  logic        reset;
  logic [31:0] mlier;
  logic [31:0] mcand;
  logic [63:0] prodt;
  logic        start;
  logic        valid;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic        vprev = 1'b0;

  multi dut (
    .clock(clock),
    .reset(reset),
    .mlier(mlier),
    .mcand(mcand),
    .prodt(prodt),
    .start(start),
    .valid(valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: every valid rise must match the oldest queued product.
  always @(negedge clock) begin
    if (valid && !vprev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL product: got %h, required none queued", prodt);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if (prodt !== e) begin
          errors++;
          $display("FAIL product: got %h, required %h", prodt, e);
        end
      end
    end
    vprev = valid;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Full operation: load, wait for valid, hold one cycle, drop start.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit scramble);
    int n;
    @(negedge clock);
    mlier = a;
    mcand = b;
    start = 1'b1;
    sb.push_back(exp);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
      if (scramble && n == 5) begin
        mlier = ~a;
        mcand = b ^ 32'h5A5A_5A5A;
      end
    end while (!valid && n < 40);
    chk("latency", 64'(n), 64'd33);
    @(posedge clock);
    #1;
    chk("done_valid", {63'd0, valid}, 64'd1);
    chk("done_prodt", prodt, exp);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    chk("gap_valid", {63'd0, valid}, 64'd0);
    chk("gap_prodt", prodt, exp);
  endtask

  initial begin
    int rose;
    reset = 1'b0;
    start = 1'b0;
    mlier = 32'd0;
    mcand = 32'd0;
    #1;
    chk("rst_prodt", prodt, 64'd0);
    chk("rst_valid", {63'd0, valid}, 64'd0);
    #20;
    @(negedge clock);
    reset = 1'b1;

    run_op(32'h8, 32'h0001_2345, 64'h91A28, 1'b0);
    run_op(32'h2, 32'h000F_FFFF, 64'h1F_FFFE, 1'b0);
    run_op(32'h4, 32'h000F_FFFF, 64'h3F_FFFC, 1'b0);
    run_op(32'h8, 32'h000F_FFFF, 64'h7F_FFF8, 1'b0);
    run_op(32'h1, 32'h0001_2345, 64'h12345, 1'b0);
    run_op(32'h0, 32'h0001_2345, 64'h0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op(32'h0001_0003, 32'h0000_0007, 64'h7_0015, 1'b1);

    // Abort: start dropped mid-BUSY, no product must appear.
    @(negedge clock);
    mlier = 32'h3;
    mcand = 32'h3;
    start = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_valid", {63'd0, valid}, 64'd0);
    chk("abort_prodt", prodt, 64'h7_0015);
    rose = 0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (valid) rose = 1;
    end
    chk("abort_quiet", 64'(rose), 64'd0);

    run_op(32'h0000_1000, 32'h0000_0011, 64'h1_1000, 1'b0);

    // Asynchronous reset between edges in the middle of BUSY.
    @(negedge clock);
    mlier = 32'h5;
    mcand = 32'h5;
    start = 1'b1;
    repeat (15) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_prodt", prodt, 64'd0);
    chk("arst_valid", {63'd0, valid}, 64'd0);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    run_op(32'h0001_2345, 32'h0000_0100, 64'h123_4500, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
